// File: rtl/core_if.sv
// Core memory protocol bundle: request/grant handshake plus in-order response channel.
interface core_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              gnt;
  logic              rvalid;
  logic              err;
  logic              we;
  logic [DATA_W/8-1:0] be;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  gnt, rvalid, err, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output gnt, rvalid, err, rdata
  );
endinterface

// File: rtl/core_arbiter.sv
// Two-master to one-slave core-protocol arbiter with an in-order owner ID FIFO.
// Define CORE_ARB_RR_EN for round-robin tie breaking; default is fixed priority to m1.
module core_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic   clk,
  input  logic   rst,
  core_if.slave  m0,
  core_if.slave  m1,
  core_if.master s,
  output logic   protocol_err
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [MAX_OUTSTANDING-1:0] fifo_q;
  logic perr_q;
  logic sel, tie_win, full, empty, req_s, push, pop, head;

`ifdef CORE_ARB_RR_EN
  logic last_q;
  assign tie_win = ~last_q;
`else
  assign tie_win = 1'b1;
`endif

  assign full  = (cnt_q == CNT_MAX);
  assign empty = (cnt_q == '0);

  always_comb begin
    sel = 1'b1;
    if (m0.req && m1.req) sel = tie_win;
    else if (m0.req)      sel = 1'b0;
  end

  // Request path: combinational mux of the selected master
  assign req_s   = (m0.req | m1.req) & ~full & ~rst;
  assign s.req   = req_s;
  assign s.we    = sel ? m1.we    : m0.we;
  assign s.be    = sel ? m1.be    : m0.be;
  assign s.addr  = sel ? m1.addr  : m0.addr;
  assign s.wdata = sel ? m1.wdata : m0.wdata;

  assign push  = req_s & s.gnt;
  assign m0.gnt = push & ~sel;
  assign m1.gnt = push &  sel;

  // Response path: head of the ID FIFO names the owner
  assign head = fifo_q[rptr_q];
  assign pop  = s.rvalid & ~empty & ~rst;

  assign m0.rvalid = pop & ~head;
  assign m1.rvalid = pop &  head;
  assign m0.err    = pop & ~head & s.err;
  assign m1.err    = pop &  head & s.err;
  assign m0.rdata  = s.rdata;
  assign m1.rdata  = s.rdata;

  assign protocol_err = perr_q;

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      perr_q <= 1'b0;
`ifdef CORE_ARB_RR_EN
      last_q <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      if (push) wptr_q <= next_ptr(wptr_q);
      if (pop)  rptr_q <= next_ptr(rptr_q);
      if (s.rvalid && empty) perr_q <= 1'b1;
`ifdef CORE_ARB_RR_EN
      if (push) last_q <= sel;
`endif
    end
  end

  // ID storage holds data only; validity is tracked by cnt_q and the pointers
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= sel;
  end
endmodule

// File: tb/tb_core_arbiter.sv
// Directed self-checking bench for core_arbiter (MAX_OUTSTANDING = 2).
module tb_core_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic protocol_err;
  int checks = 0;
  int errors = 0;

  core_if m0_if ();
  core_if m1_if ();
  core_if s_if ();

  core_arbiter #(.MAX_OUTSTANDING(2)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if), .s(s_if),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  task automatic idle();
    m0_if.req = 0; m0_if.we = 0; m0_if.be = 4'hF; m0_if.addr = 32'h100; m0_if.wdata = 32'h0;
    m1_if.req = 0; m1_if.we = 1; m1_if.be = 4'h3; m1_if.addr = 32'h200; m1_if.wdata = 32'h55;
    s_if.gnt = 0; s_if.rvalid = 0; s_if.err = 0; s_if.rdata = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic reset_dut();
    idle(); rst = 1; next_cycle(); rst = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    m0_if.req = 1; m1_if.req = 1; s_if.gnt = 1; s_if.rvalid = 1; s_if.err = 1;
    next_cycle();
    @(negedge clk);
    checks++; if (s_if.req !== 1'b0) begin errors++; $display("FAIL rst_sreq got %b want 0", s_if.req); end
    checks++; if ({m0_if.gnt, m1_if.gnt} !== 2'b00) begin errors++; $display("FAIL rst_gnt got %b want 00", {m0_if.gnt, m1_if.gnt}); end
    checks++; if ({m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err} !== 4'b0) begin errors++; $display("FAIL rst_rsp got %b want 0000", {m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err}); end
    checks++; if (dut.cnt_q !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", dut.cnt_q); end
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL rst_perr got %b want 0", protocol_err); end
    next_cycle();
    rst = 0; idle();
  endtask

  task automatic test_single();
    reset_dut();
    for (int k = 0; k <= 4; k++) begin
      m0_if.req = (k < 4); m0_if.addr = 32'(4 * k);
      s_if.gnt = 1; s_if.rvalid = (k > 0); s_if.rdata = 32'hD000 + 32'(k - 1);
      @(negedge clk);
      if (k < 4) begin
        checks++; if (m0_if.gnt !== 1'b1 || s_if.addr !== 32'(4 * k)) begin errors++; $display("FAIL single_gnt%0d gnt %b addr %h want 1 %h", k, m0_if.gnt, s_if.addr, 4 * k); end
      end else begin
        checks++; if (s_if.req !== 1'b0) begin errors++; $display("FAIL single_idle_req got %b want 0", s_if.req); end
      end
      checks++; if (m1_if.gnt !== 1'b0 || m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL single_m1_%0d gnt %b rvalid %b want 0 0", k, m1_if.gnt, m1_if.rvalid); end
      if (k > 0) begin
        checks++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'hD000 + 32'(k - 1)) begin errors++; $display("FAIL single_rsp%0d rvalid %b rdata %h want 1 %h", k, m0_if.rvalid, m0_if.rdata, 32'hD000 + k - 1); end
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++; if (dut.cnt_q !== 2'd0) begin errors++; $display("FAIL single_cnt got %0d want 0", dut.cnt_q); end
    next_cycle();
  endtask

  task automatic test_tie();
    logic w [0:5];
    for (int k = 0; k < 6; k++) begin
`ifdef CORE_ARB_RR_EN
      w[k] = ((k % 2) == 0);
`else
      w[k] = 1'b1;
`endif
    end
    reset_dut();
    for (int k = 0; k <= 6; k++) begin
      m0_if.req = (k < 6); m1_if.req = (k < 6);
      s_if.gnt = 1; s_if.rvalid = (k > 0); s_if.rdata = 32'hA000 + 32'(k);
      @(negedge clk);
      if (k < 6) begin
        checks++; if (m1_if.gnt !== w[k] || m0_if.gnt !== !w[k]) begin errors++; $display("FAIL tie_gnt%0d m1 %b m0 %b want m1 %b", k, m1_if.gnt, m0_if.gnt, w[k]); end
        checks++; if (s_if.addr !== (w[k] ? 32'h200 : 32'h100) || s_if.we !== w[k]) begin errors++; $display("FAIL tie_mux%0d addr %h we %b", k, s_if.addr, s_if.we); end
      end
      if (k > 0) begin
        checks++; if (m1_if.rvalid !== w[k-1] || m0_if.rvalid !== !w[k-1]) begin errors++; $display("FAIL tie_rsp%0d m1 %b m0 %b want m1 %b", k, m1_if.rvalid, m0_if.rvalid, w[k-1]); end
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_backpressure();
    reset_dut();
    m0_if.req = 1; s_if.gnt = 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++; if (s_if.req !== 1'b1 || m0_if.gnt !== 1'b1) begin errors++; $display("FAIL bp_hs%0d req %b gnt %b want 1 1", k, s_if.req, m0_if.gnt); end
      next_cycle();
    end
    @(negedge clk);
    checks++; if (s_if.req !== 1'b0 || m0_if.gnt !== 1'b0) begin errors++; $display("FAIL bp_full req %b gnt %b want 0 0", s_if.req, m0_if.gnt); end
    next_cycle();
    s_if.rvalid = 1;
    @(negedge clk);
    checks++; if (s_if.req !== 1'b0 || m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL bp_bubble req %b rvalid %b want 0 1", s_if.req, m0_if.rvalid); end
    next_cycle();
    s_if.rvalid = 0;
    @(negedge clk);
    checks++; if (s_if.req !== 1'b1 || dut.cnt_q !== 2'd1) begin errors++; $display("FAIL bp_resume req %b cnt %0d want 1 1", s_if.req, dut.cnt_q); end
    next_cycle();
    m0_if.req = 0; s_if.rvalid = 1;
    next_cycle(); next_cycle();
    s_if.rvalid = 0;
    @(negedge clk);
    checks++; if (dut.cnt_q !== 2'd0) begin errors++; $display("FAIL bp_drain cnt %0d want 0", dut.cnt_q); end
    next_cycle();
    idle();
  endtask

  task automatic test_interleave();
    reset_dut();
    s_if.gnt = 1;
    m0_if.req = 1;
    next_cycle();
    m0_if.req = 0; m1_if.req = 1; s_if.rvalid = 1; s_if.err = 0;
    @(negedge clk);
    checks++; if (m1_if.gnt !== 1'b1 || m0_if.rvalid !== 1'b1 || m0_if.err !== 1'b0 || m1_if.rvalid !== 1'b0) begin errors++; $display("FAIL il_r0 m1gnt %b m0rv %b m0err %b m1rv %b want 1 1 0 0", m1_if.gnt, m0_if.rvalid, m0_if.err, m1_if.rvalid); end
    next_cycle();
    m1_if.req = 0; m0_if.req = 1; s_if.err = 1;
    @(negedge clk);
    checks++; if (m0_if.gnt !== 1'b1 || m1_if.rvalid !== 1'b1 || m1_if.err !== 1'b1 || m0_if.rvalid !== 1'b0 || m0_if.err !== 1'b0) begin errors++; $display("FAIL il_r1 m0gnt %b m1rv %b m1err %b m0rv %b m0err %b want 1 1 1 0 0", m0_if.gnt, m1_if.rvalid, m1_if.err, m0_if.rvalid, m0_if.err); end
    next_cycle();
    m0_if.req = 0; s_if.err = 0;
    @(negedge clk);
    checks++; if (m0_if.rvalid !== 1'b1 || m0_if.err !== 1'b0 || m1_if.rvalid !== 1'b0 || m1_if.err !== 1'b0) begin errors++; $display("FAIL il_r2 m0rv %b m0err %b m1rv %b m1err %b want 1 0 0 0", m0_if.rvalid, m0_if.err, m1_if.rvalid, m1_if.err); end
    next_cycle();
    idle();
  endtask

  task automatic test_stray();
    reset_dut();
    s_if.rvalid = 1; s_if.err = 1;
    @(negedge clk);
    checks++; if ({m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err} !== 4'b0) begin errors++; $display("FAIL stray_route got %b want 0000", {m0_if.rvalid, m1_if.rvalid, m0_if.err, m1_if.err}); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (protocol_err !== 1'b1 || dut.cnt_q !== 2'd0) begin errors++; $display("FAIL stray_set perr %b cnt %0d want 1 0", protocol_err, dut.cnt_q); end
    next_cycle(); next_cycle();
    @(negedge clk);
    checks++; if (protocol_err !== 1'b1) begin errors++; $display("FAIL stray_hold perr %b want 1", protocol_err); end
    next_cycle();
    reset_dut();
    @(negedge clk);
    checks++; if (protocol_err !== 1'b0) begin errors++; $display("FAIL stray_clr perr %b want 0", protocol_err); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    reset_dut();
    m0_if.req = 1; s_if.gnt = 1;
    next_cycle(); next_cycle();
    rst = 1;
    @(negedge clk);
    checks++; if (dut.cnt_q !== 2'd2 || s_if.req !== 1'b0 || m0_if.gnt !== 1'b0) begin errors++; $display("FAIL rmid_during cnt %0d req %b gnt %b want 2 0 0", dut.cnt_q, s_if.req, m0_if.gnt); end
    next_cycle();
    rst = 0;
    @(negedge clk);
    checks++; if (dut.cnt_q !== 2'd0 || s_if.req !== 1'b1 || m0_if.gnt !== 1'b1) begin errors++; $display("FAIL rmid_after cnt %0d req %b gnt %b want 0 1 1", dut.cnt_q, s_if.req, m0_if.gnt); end
    next_cycle();
    m0_if.req = 0; s_if.rvalid = 1;
    @(negedge clk);
    checks++; if (m0_if.rvalid !== 1'b1) begin errors++; $display("FAIL rmid_rsp rvalid %b want 1", m0_if.rvalid); end
    next_cycle();
    idle();
    @(negedge clk);
    checks++; if (dut.cnt_q !== 2'd0 || protocol_err !== 1'b0) begin errors++; $display("FAIL rmid_end cnt %0d perr %b want 0 0", dut.cnt_q, protocol_err); end
    next_cycle();
  endtask

  initial begin
    rst = 1; idle();
    #1;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_interleave();
    test_stray();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/core_arbiter.md
# core_arbiter

Two-master, one-slave arbiter for the core memory interface. It lets the Ibex instruction port and data port share a single core-protocol memory port, such as the memory behind a Wishbone-to-core converter. It picks one requester per cycle and forwards its request. It records which master owns each outstanding transaction in an in-order ID FIFO, and returns each response to its owner.

## Interface
- `MAX_OUTSTANDING`, default 2: maximum number of granted transactions awaiting `rvalid`; legal range 1..8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `m0`  core_if.slave  bundle: master 0, instruction port (req, gnt, rvalid, err, we, be, addr, wdata, rdata).
- `m1`  core_if.slave  bundle: master 1, data port.
- `s`  core_if.master  bundle: shared downstream memory port.
- `protocol_err`  out  1: sticky flag, set by `s.rvalid` while no transaction is outstanding; cleared only by `rst`.

## Operation
- Request path is combinational.
  - `s.req = (m0.req | m1.req) & ~full`.
  - `s.we`, `s.be`, `s.addr` and `s.wdata` come from the selected master `sel`.
- Selection:
  - If only one master requests, it is selected.
  - If both request, the tie is broken by the priority rule (see Configuration).
- Grant:
  - `mX.gnt = s.gnt & s.req & (sel == X)`.
  - The unselected master sees `gnt = 0` and holds its request.
- A handshake occurs when `s.req & s.gnt`. It pushes `sel` (1 bit) into the ID FIFO.
- Response path:
  - On `s.rvalid` with the FIFO non-empty, the head ID selects the owner.
  - Owner gets `mX.rvalid = 1`, `mX.err = s.err`, `mX.rdata = s.rdata`; the FIFO pops.
  - The other master sees `rvalid = 0` and `err = 0`.
  - `rdata` is driven to both masters unconditionally.
- Outstanding counter `cnt`, width `$clog2(MAX_OUTSTANDING+1)`:
  - +1 on push, −1 on pop, unchanged on simultaneous push and pop.
  - `full = (cnt == MAX_OUTSTANDING)`; `empty = (cnt == 0)`.
- Full with a pop in the same cycle: `full` is evaluated on the registered `cnt`, so no new request issues that cycle. This costs one bubble but keeps the path free of a combinational `rvalid`→`req` dependency.
- Stray response (`s.rvalid` while empty):
  - Not routed to either master.
  - No pop; `cnt` unchanged.
  - `protocol_err` ← 1.
- Responses return strictly in grant order; the downstream slave must be in-order.
- FIFO read and write pointers wrap modulo `MAX_OUTSTANDING`.

## Timing
- Request to downstream: 0 cycles, combinational; grant back to the master: 0 cycles, same cycle as `s.gnt`.
- Response to master: 0 cycles, combinational from `s.rvalid`; the earliest response is the cycle after its grant.
- Zero-latency responses (rvalid in the grant cycle) are not supported.
- Sustained throughput is one transaction per cycle while `MAX_OUTSTANDING ≥ 2` and the downstream returns in one cycle.
- Reset values:
  - `cnt = 0`, FIFO empty, both FIFO pointers = 0.
  - `protocol_err = 0`.
  - Round-robin pointer favours m1 (data) first.
- While `rst` is high:
  - `s.req = 0`.
  - All `mX.gnt`, `mX.rvalid` and `mX.err` are forced to 0.
- Reset mid-transaction discards all outstanding IDs. Late `rvalid` from the slave after reset then sets `protocol_err`; the system must reset the slave together with the arbiter.

## Configuration
- `CORE_ARB_RR_EN` defined: round-robin.
  - A 1-bit `last` register updates to `sel` on each handshake.
  - On a tie, the master not equal to `last` wins.
  - Reset value `last = 0`, so m1 wins the first tie.
- `CORE_ARB_RR_EN` undefined: fixed priority, m1 (data) always wins ties; no `last` register is built.

## Test plan
- Single master: m0 issues 4 reads to addr 0x0, 0x4, 0x8, 0xC; slave has 1-cycle latency → m0 gets 4 gnts and 4 rvalids with matching rdata; m1 sees no `gnt` or `rvalid`; `cnt` returns to 0.
- Tie with both masters requesting every cycle for 6 cycles:
  - `CORE_ARB_RR_EN` defined: grant order m1, m0, m1, m0, m1, m0.
  - Undefined: m1 is granted all 6 and m0 `gnt` stays 0.
- Backpressure: `MAX_OUTSTANDING=2`, slave withholds `rvalid` → after 2 handshakes `s.req = 0` despite pending requests. `rvalid` is then returned in the next cycle → `s.req` reasserts one cycle later.
- Interleaved ownership: grants m0, m1, m0 with responses err = 0, 1, 0 → rvalid goes to m0, then m1 with `err = 1`, then m0; the err path is correctly routed.
- Stray response: after reset, drive `s.rvalid` with `cnt = 0` → no master rvalid, `protocol_err = 1` and held until `rst`.
- Reset mid-operation: assert `rst` for 1 cycle with 2 outstanding → `cnt = 0`, `s.req = 0` during reset, normal grants resume the following cycle.
